// File: rtl/alu_stack_pkg.sv
// Shared definitions for the ALU stack sequencer: command opcodes, error
// codes and the sequencer FSM state encoding.
package alu_stack_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned ERR_W  = 2;

  // Command opcodes; 3..8 are passed straight through to the ALU.
  localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OP_W-1:0] OP_PUSH = 4'd1;
  localparam logic [OP_W-1:0] OP_POP  = 4'd2;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd3;
  localparam logic [OP_W-1:0] OP_OR   = 4'd4;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd5;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd6;
  localparam logic [OP_W-1:0] OP_NOR  = 4'd7;
  localparam logic [OP_W-1:0] OP_AND  = 4'd8;

  localparam logic [ERR_W-1:0] ERR_NONE = 2'b00;
  localparam logic [ERR_W-1:0] ERR_OVF  = 2'b01;
  localparam logic [ERR_W-1:0] ERR_UNF  = 2'b10;
  localparam logic [ERR_W-1:0] ERR_ILL  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } seq_state_e;

endpackage

// File: rtl/operand_lifo.sv
// Operand LIFO: DEPTH x 32 storage plus stack pointer.
// Ports: push/push_data write mem[sp] and increment sp; pop drops one entry;
// pop2 drops two. top_c/next_c read mem[sp-1]/mem[sp-2]. sp is the registered
// occupancy; full_c/empty_c/has2_c are flags decoded from it.
module operand_lifo
  import alu_stack_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned SP_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              pop2,
  output logic [DATA_W-1:0] top_c,
  output logic [DATA_W-1:0] next_c,
  output logic [SP_W-1:0]   sp,
  output logic              full_c,
  output logic              empty_c,
  output logic              has2_c
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [SP_W-1:0]   sp_q;
  logic [SP_W-1:0]   sp_d;

  // Pointer update; the caller never requests more than one action per cycle.
  always_comb begin
    sp_d = sp_q;
    if (push) begin
      sp_d = sp_q + SP_W'(1);
    end else if (pop) begin
      sp_d = sp_q - SP_W'(1);
    end else if (pop2) begin
      sp_d = sp_q - SP_W'(2);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Storage is not reset: only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[IDX_W'(sp_q)] <= push_data;
    end
  end

  assign top_c   = mem_q[IDX_W'(sp_q - SP_W'(1))];
  assign next_c  = mem_q[IDX_W'(sp_q - SP_W'(2))];
  assign sp      = sp_q;
  assign full_c  = (sp_q == SP_W'(DEPTH));
  assign empty_c = (sp_q == '0);
  assign has2_c  = (sp_q >= SP_W'(2));

endmodule

// File: rtl/alu_stack_sequencer.sv
// Stack-machine front end for an external 32-bit ALU.
// Ports: cmd_valid/cmd_ready/cmd_op/cmd_data command handshake; alu_a/alu_b/
// alu_op_o drive the ALU and alu_result/alu_zero come back; res_valid/
// res_data/res_zero report popped values and ALU results; err_valid/err_code
// report overflow, underflow and illegal ops; depth is the stack occupancy;
// busy is high whenever the FSM is not idle.
module alu_stack_sequencer
  import alu_stack_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned SP_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op_o,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero,
  output logic              err_valid,
  output logic [ERR_W-1:0]  err_code,
  output logic [SP_W-1:0]   depth,
  output logic              busy
);

  seq_state_e        state_q, state_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_zero_q, res_zero_d;
  logic              err_valid_q, err_valid_d;
  logic [ERR_W-1:0]  err_code_q, err_code_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;

  logic              lifo_push, lifo_pop, lifo_pop2;
  logic [DATA_W-1:0] lifo_push_data;
  logic [DATA_W-1:0] top_c, next_c;
  logic              full_c, empty_c, has2_c;

  operand_lifo #(.DEPTH(DEPTH)) u_lifo (
    .clk       (clk),
    .reset     (reset),
    .push      (lifo_push),
    .push_data (lifo_push_data),
    .pop       (lifo_pop),
    .pop2      (lifo_pop2),
    .top_c     (top_c),
    .next_c    (next_c),
    .sp        (depth),
    .full_c    (full_c),
    .empty_c   (empty_c),
    .has2_c    (has2_c)
  );

  // Next-state, LIFO control and output register inputs.
  // The ALU operand registers double as the EXEC-cycle drivers, so they are
  // loaded only on an ALU accept and fall back to zero everywhere else.
  always_comb begin
    state_d        = state_q;
    res_valid_d    = 1'b0;
    res_data_d     = res_data_q;
    res_zero_d     = res_zero_q;
    err_valid_d    = 1'b0;
    err_code_d     = err_code_q;
    alu_a_d        = '0;
    alu_b_d        = '0;
    alu_op_d       = '0;
    lifo_push      = 1'b0;
    lifo_pop       = 1'b0;
    lifo_pop2      = 1'b0;
    lifo_push_data = cmd_data;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_NOP: ;
            OP_PUSH: begin
              if (full_c) begin
                err_valid_d = 1'b1;
                err_code_d  = ERR_OVF;
              end else begin
                lifo_push = 1'b1;
              end
            end
            OP_POP: begin
              if (empty_c) begin
                err_valid_d = 1'b1;
                err_code_d  = ERR_UNF;
              end else begin
                lifo_pop    = 1'b1;
                res_valid_d = 1'b1;
                res_data_d  = top_c;
                res_zero_d  = (top_c == '0);
              end
            end
            OP_ADD, OP_OR, OP_SUB, OP_SLT, OP_NOR, OP_AND: begin
              if (!has2_c) begin
                err_valid_d = 1'b1;
                err_code_d  = ERR_UNF;
              end else begin
                lifo_pop2 = 1'b1;
                alu_a_d   = next_c;
                alu_b_d   = top_c;
                alu_op_d  = cmd_op;
                state_d   = ST_EXEC;
              end
            end
            default: begin
              err_valid_d = 1'b1;
              err_code_d  = ERR_ILL;
            end
          endcase
        end
      end
      ST_EXEC: begin
        // Two entries were freed on accept, so the result push cannot overflow.
        lifo_push      = 1'b1;
        lifo_push_data = alu_result;
        res_valid_d    = 1'b1;
        res_data_d     = alu_result;
        res_zero_d     = alu_zero;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op_o  = alu_op_q;

endmodule

// File: tb/tb_alu_stack_sequencer.sv
// Directed bench for alu_stack_sequencer with a behavioural 32-bit ALU
// attached to the ALU ports.
module tb_alu_stack_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'd0;
  logic [31:0] cmd_data = 32'd0;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_zero;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [3:0]  depth;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_stack_sequencer #(.DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op_o   (alu_op_o),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_zero   (res_zero),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .depth      (depth),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // External ALU: 3 ADD, 4 OR, 5 SUB, 6 SLT (unsigned), 7 NOR, 8 AND, else 0.
  always_comb begin
    case (alu_op_o)
      4'd3:    alu_result = alu_a + alu_b;
      4'd4:    alu_result = alu_a | alu_b;
      4'd5:    alu_result = alu_a - alu_b;
      4'd6:    alu_result = {31'd0, (alu_a < alu_b)};
      4'd7:    alu_result = ~(alu_a | alu_b);
      4'd8:    alu_result = alu_a & alu_b;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  // Drive one command at a negedge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] data);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || depth !== 4'd0 || res_valid !== 1'b0 ||
        err_valid !== 1'b0 || res_data !== 32'd0 || res_zero !== 1'b0 || err_code !== 2'd0 ||
        alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op_o !== 4'd0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b busy=%b depth=%0d rv=%b ev=%b rd=%h rz=%b ec=%0d a=%h b=%h op=%0d required rdy=1 busy=1'b0 rest 0",
               cmd_ready, busy, depth, res_valid, err_valid, res_data, res_zero, err_code, alu_a, alu_b, alu_op_o);
    end
  endtask

  task automatic test_sub();
    do_reset();
    issue(4'd1, 32'd7);
    issue(4'd1, 32'd5);
    issue(4'd5, 32'd0);
    @(negedge clk);
    total++;
    if (alu_a !== 32'd7 || alu_b !== 32'd5 || alu_op_o !== 4'd5 || busy !== 1'b1 ||
        cmd_ready !== 1'b0 || depth !== 4'd0 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL sub_exec: a=%0d b=%0d op=%0d busy=%b rdy=%b depth=%0d rv=%b required 7 5 5 1 0 0 0",
               alu_a, alu_b, alu_op_o, busy, cmd_ready, depth, res_valid);
    end
    @(negedge clk);
    total++;
    if (res_valid !== 1'b1 || res_data !== 32'd2 || res_zero !== 1'b0 || depth !== 4'd1 ||
        alu_op_o !== 4'd0 || err_valid !== 1'b0) begin
      bad++;
      $display("FAIL sub_result: rv=%b rd=%0d rz=%b depth=%0d op=%0d ev=%b required 1 2 0 1 0 0",
               res_valid, res_data, res_zero, depth, alu_op_o, err_valid);
    end
    @(negedge clk);
    total++;
    if (res_valid !== 1'b0) begin
      bad++;
      $display("FAIL sub_pulse_width: rv=%b required 0", res_valid);
    end
  endtask

  task automatic test_zero_then_pop();
    do_reset();
    issue(4'd1, 32'd3);
    issue(4'd1, 32'd3);
    issue(4'd5, 32'd0);
    repeat (2) @(negedge clk);
    total++;
    if (res_valid !== 1'b1 || res_data !== 32'd0 || res_zero !== 1'b1 || depth !== 4'd1) begin
      bad++;
      $display("FAIL sub_zero: rv=%b rd=%0d rz=%b depth=%0d required 1 0 1 1",
               res_valid, res_data, res_zero, depth);
    end
    issue(4'd2, 32'd0);
    @(negedge clk);
    total++;
    if (res_valid !== 1'b1 || res_data !== 32'd0 || res_zero !== 1'b1 || depth !== 4'd0 ||
        err_valid !== 1'b0) begin
      bad++;
      $display("FAIL pop_zero: rv=%b rd=%0d rz=%b depth=%0d ev=%b required 1 0 1 0 0",
               res_valid, res_data, res_zero, depth, err_valid);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    issue(4'd1, 32'd1);
    issue(4'd3, 32'd0);
    @(negedge clk);
    total++;
    if (err_valid !== 1'b1 || err_code !== 2'b10 || res_valid !== 1'b0 || depth !== 4'd1 ||
        busy !== 1'b0) begin
      bad++;
      $display("FAIL unf_add: ev=%b ec=%b rv=%b depth=%0d busy=%b required 1 10 0 1 0",
               err_valid, err_code, res_valid, depth, busy);
    end
    do_reset();
    issue(4'd2, 32'd0);
    @(negedge clk);
    total++;
    if (err_valid !== 1'b1 || err_code !== 2'b10 || res_valid !== 1'b0 || depth !== 4'd0) begin
      bad++;
      $display("FAIL unf_pop: ev=%b ec=%b rv=%b depth=%0d required 1 10 0 0",
               err_valid, err_code, res_valid, depth);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 8; i++) issue(4'd1, 32'(i));
    @(negedge clk);
    total++;
    if (depth !== 4'd8 || err_valid !== 1'b0) begin
      bad++;
      $display("FAIL fill_depth: depth=%0d ev=%b required 8 0", depth, err_valid);
    end
    issue(4'd1, 32'd9);
    @(negedge clk);
    total++;
    if (err_valid !== 1'b1 || err_code !== 2'b01 || depth !== 4'd8 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovf_push: ev=%b ec=%b depth=%0d rv=%b required 1 01 8 0",
               err_valid, err_code, depth, res_valid);
    end
    issue(4'd2, 32'd0);
    @(negedge clk);
    total++;
    if (res_valid !== 1'b1 || res_data !== 32'd8 || depth !== 4'd7 || err_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovf_pop: rv=%b rd=%0d depth=%0d ev=%b required 1 8 7 0",
               res_valid, res_data, depth, err_valid);
    end
  endtask

  task automatic test_edge_ops();
    do_reset();
    issue(4'd15, 32'd0);
    @(negedge clk);
    total++;
    if (err_valid !== 1'b1 || err_code !== 2'b11 || res_valid !== 1'b0 || depth !== 4'd0) begin
      bad++;
      $display("FAIL illegal_op: ev=%b ec=%b rv=%b depth=%0d required 1 11 0 0",
               err_valid, err_code, res_valid, depth);
    end
    issue(4'd1, 32'd2);
    issue(4'd0, 32'd0);
    @(negedge clk);
    total++;
    if (err_valid !== 1'b0 || res_valid !== 1'b0 || depth !== 4'd1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL nop: ev=%b rv=%b depth=%0d busy=%b required 0 0 1 0",
               err_valid, res_valid, depth, busy);
    end
    issue(4'd1, 32'd9);
    issue(4'd6, 32'd0);
    repeat (2) @(negedge clk);
    total++;
    if (res_valid !== 1'b1 || res_data !== 32'd1 || res_zero !== 1'b0 || depth !== 4'd1) begin
      bad++;
      $display("FAIL slt: rv=%b rd=%0d rz=%b depth=%0d required 1 1 0 1",
               res_valid, res_data, res_zero, depth);
    end
    do_reset();
    issue(4'd1, 32'd0);
    issue(4'd1, 32'd0);
    issue(4'd7, 32'd0);
    repeat (2) @(negedge clk);
    total++;
    if (res_valid !== 1'b1 || res_data !== 32'hFFFF_FFFF || res_zero !== 1'b0 || depth !== 4'd1) begin
      bad++;
      $display("FAIL nor: rv=%b rd=%h rz=%b depth=%0d required 1 ffffffff 0 1",
               res_valid, res_data, res_zero, depth);
    end
  endtask

  // Hold an ADD on cmd_valid across EXEC: it must be taken again only once idle.
  task automatic test_back_to_back();
    do_reset();
    issue(4'd1, 32'd1);
    issue(4'd1, 32'd2);
    issue(4'd1, 32'd3);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 4'd3;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b0 || alu_a !== 32'd2 || alu_b !== 32'd3 || depth !== 4'd1) begin
      bad++;
      $display("FAIL b2b_exec1: rdy=%b a=%0d b=%0d depth=%0d required 0 2 3 1",
               cmd_ready, alu_a, alu_b, depth);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (res_valid !== 1'b1 || res_data !== 32'd5 || cmd_ready !== 1'b1 || depth !== 4'd2) begin
      bad++;
      $display("FAIL b2b_res1: rv=%b rd=%0d rdy=%b depth=%0d required 1 5 1 2",
               res_valid, res_data, cmd_ready, depth);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || alu_a !== 32'd1 || alu_b !== 32'd5 || depth !== 4'd0) begin
      bad++;
      $display("FAIL b2b_exec2: busy=%b a=%0d b=%0d depth=%0d required 1 1 5 0",
               busy, alu_a, alu_b, depth);
    end
    @(negedge clk);
    total++;
    if (res_valid !== 1'b1 || res_data !== 32'd6 || depth !== 4'd1) begin
      bad++;
      $display("FAIL b2b_res2: rv=%b rd=%0d depth=%0d required 1 6 1",
               res_valid, res_data, depth);
    end
  endtask

  task automatic test_reset_mid_exec();
    int seen;
    do_reset();
    issue(4'd1, 32'd4);
    issue(4'd1, 32'd6);
    issue(4'd3, 32'd0);
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_exec_busy: busy=%b required 1", busy);
    end
    reset = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b1 || depth !== 4'd0 || busy !== 1'b0 || alu_op_o !== 4'd0) begin
      bad++;
      $display("FAIL mid_exec_reset: rdy=%b depth=%0d busy=%b op=%0d required 1 0 0 0",
               cmd_ready, depth, busy, alu_op_o);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || err_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL mid_exec_no_pulse: pulse_cycles=%0d required 0", seen);
    end
    issue(4'd1, 32'hCAFE_0042);
    issue(4'd2, 32'd0);
    @(negedge clk);
    total++;
    if (res_valid !== 1'b1 || res_data !== 32'hCAFE_0042 || depth !== 4'd0) begin
      bad++;
      $display("FAIL post_reset_roundtrip: rv=%b rd=%h depth=%0d required 1 cafe0042 0",
               res_valid, res_data, depth);
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_zero_then_pop();
    test_underflow();
    test_overflow();
    test_edge_ops();
    test_back_to_back();
    test_reset_mid_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_stack_sequencer.md
Name: alu_stack_sequencer

Overview:
Stack-machine front end for the 32-bit ALU. Accepts one command per handshake (PUSH, POP, NOP or an ALU op) and keeps a small operand LIFO. For ALU ops it pops two operands, drives the ALU for one cycle, and pushes the result back. The ALU is instantiated beside this block, not inside it: this block drives the ALU inputs and reads `result` and `zero` back.

Parameters:
- DEPTH, 8, number of LIFO entries (must be 2 or more).
- SP_W, $clog2(DEPTH+1), width of the stack pointer and depth count. Localparam, not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_op  in  4  0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 OR, 5 SUB, 6 SLT, 7 NOR, 8 AND, 9-15 illegal.
- cmd_data  in  32  push value; ignored for all other ops.
- alu_a  out  32  to ALU data_in_1st.
- alu_b  out  32  to ALU data_in_2nd.
- alu_op_o  out  4  to ALU alu_op.
- alu_result  in  32  from ALU result.
- alu_zero  in  1  from ALU zero.
- res_valid  out  1  one-cycle pulse; res_data and res_zero are valid in that cycle.
- res_data  out  32  popped value or ALU result.
- res_zero  out  1  res_data == 0.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  01 overflow, 10 underflow, 11 illegal op.
- depth  out  SP_W  current number of occupied entries.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values:
  - state = IDLE, sp = 0, cmd_ready = 1.
  - res_valid = 0, err_valid = 0, res_data = 0, res_zero = 0, err_code = 0.
  - alu_a = 0, alu_b = 0, alu_op_o = 0.
  - LIFO storage is not reset; only entries below sp are ever read.
- Accept rule: a command is accepted when cmd_valid and cmd_ready are both high at a rising edge. cmd_ready = (state == IDLE).
- FSM states: IDLE and EXEC.
- IDLE, on accept:
  - NOP: no effect.
  - PUSH:
    - If sp == DEPTH: err_valid pulses next cycle with code 01; stack unchanged.
    - Otherwise: mem[sp] <= cmd_data, sp++. No res_valid. Stay in IDLE.
  - POP:
    - If sp == 0: err 10.
    - Otherwise: sp--, res_data <= mem[sp-1], res_valid pulses in the next cycle (latency 1).
  - ALU op (3-8):
    - If sp < 2: err 10; stack unchanged; stay in IDLE.
    - Otherwise: opA <= mem[sp-2], opB <= mem[sp-1], opR <= cmd_op, sp <= sp-2, go to EXEC.
  - 9-15: err 11; no other effect.
- EXEC (exactly one cycle):
  - alu_a = opA (earlier-pushed operand), alu_b = opB (top of stack), alu_op_o = opR. SUB gives a-b; SLT gives a<b, unsigned.
  - At the end of the cycle: mem[sp] <= alu_result, sp++, res_data <= alu_result, res_zero <= alu_zero. Go to IDLE.
  - res_valid pulses in the cycle after EXEC: latency 2 from accept. Throughput is one ALU op per 2 cycles.
- Outside EXEC, alu_a, alu_b and alu_op_o are 0. The ALU default case then outputs 0.
- Net depth effect of an ALU op is -1. Overflow is impossible on the result push because two entries were freed.
- err_valid and res_valid never assert in the same cycle.
- The depth output equals sp and is registered. It updates in the cycle after a PUSH/POP accept, and in EXEC for ALU ops (depth shows sp-2 during EXEC).
- Commands arriving while cmd_ready is low are not consumed. The requester holds them.
- Reset asserted mid-EXEC: immediately return to IDLE with sp = 0. The in-flight result is discarded; no res_valid and no err_valid.

Decomposition:
- Package alu_stack_pkg holds:
  - opcode constants OP_NOP, OP_PUSH, OP_POP, OP_ADD=3, OP_OR=4, OP_SUB=5, OP_SLT=6, OP_NOR=7, OP_AND=8. The ALU values must match the ALU's parameter encodings.
  - error codes ERR_OVF, ERR_UNF, ERR_ILL.
  - the FSM state enum.
- Sub-module operand_lifo holds DEPTH x 32 storage and sp. It provides push/pop/pop2 controls, top and next-to-top read ports, and full/empty/has2 flags.
- The sequencer FSM and output registers stay in alu_stack_sequencer.

Test Plan:
1. PUSH 7, PUSH 5, SUB:
   - in EXEC: alu_a = 7, alu_b = 5, alu_op_o = 5.
   - res_valid 2 cycles after accept with res_data = 2, res_zero = 0; depth = 1.
2. PUSH 3, PUSH 3, SUB:
   - res_data = 0, res_zero = 1.
   - then POP: res_valid 1 cycle later, res_data = 0, depth = 0.
3. Underflow cases, each -> err_valid, err_code = 10, no res_valid:
   - after reset, PUSH 1 then ADD: depth stays 1.
   - POP with depth 0: depth stays 0.
4. Overflow: PUSH 1..8 (DEPTH = 8), then PUSH 9:
   - err code 01, depth = 8.
   - the following POP returns 8.
5. Edge ops:
   - cmd_op = 15 -> err 11.
   - NOP -> no pulses, depth unchanged.
   - PUSH 2, PUSH 9, SLT -> res_data = 1.
   - PUSH 0, PUSH 0, NOR -> res_data = 32'hFFFFFFFF.
6. Reset mid-EXEC: PUSH 4, PUSH 6, ADD, then pulse reset during EXEC:
   - cmd_ready = 1, depth = 0, busy = 0.
   - no res_valid after release.
   - a new PUSH/POP round-trip returns the correct value.
